// File: rtl/dft_bin_scheduler_pkg.sv
// Shared types, widths and the saturating helper for the DFT bin scheduler.
package dft_pkg;

    localparam int BIN_W    = 5;
    localparam int SAMPLE_W = 16;
    localparam int MAG_W    = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        ADVANCE
    } state_t;

    // Clamp a 33-bit unsigned result to the 32-bit accumulator range.
    function automatic logic [MAG_W-1:0] sat32(input logic [MAG_W:0] value);
        return value[MAG_W] ? {MAG_W{1'b1}} : value[MAG_W-1:0];
    endfunction

endpackage

// File: rtl/dft_bin_scheduler_if.sv
// Sample intake, multiplier/table and result signals between the scheduler and its environment.
interface dft_bin_scheduler_if;
    import dft_pkg::*;

    logic signed [SAMPLE_W-1:0] inSample;
    logic                       sampleValid;
    logic                       sampleReady;
    logic                       sampleDropped;
    logic [BIN_W-1:0]           bin;
    logic signed [SAMPLE_W-1:0] multSample;
    logic [MAG_W-1:0]           magnitude;
    logic                       enableIncr;
    logic [BIN_W-1:0]           outBin;
    logic [MAG_W-1:0]           outValue;
    logic                       outValid;
    logic                       frameDone;

    modport master (
        input  inSample, sampleValid, magnitude,
        output sampleReady, sampleDropped, bin, multSample, enableIncr,
        output outBin, outValue, outValid, frameDone
    );

    modport slave (
        output inSample, sampleValid, magnitude,
        input  sampleReady, sampleDropped, bin, multSample, enableIncr,
        input  outBin, outValue, outValid, frameDone
    );

endinterface

// File: rtl/dft_bin_scheduler_accum.sv
// Leaky accumulator update for one bin: acc - (acc >> DECAY_SHIFT) + (magnitude >> MAG_SHIFT), saturated.
module dft_bin_accum
    import dft_pkg::*;
#(
    parameter int DECAY_SHIFT = 4,
    parameter int MAG_SHIFT   = 2
) (
    input  logic [MAG_W-1:0] acc,
    input  logic [MAG_W-1:0] magnitude,
    output logic [MAG_W-1:0] acc_new
);

    logic [MAG_W-1:0] leaked;
    logic [MAG_W:0]   sum;

    always_comb begin
        leaked  = acc - (acc >> DECAY_SHIFT);
        sum     = {1'b0, leaked} + {1'b0, magnitude >> MAG_SHIFT};
        acc_new = sat32(sum);
    end

endmodule

// File: rtl/dft_bin_scheduler.sv
// Walks every DFT bin once per accepted sample, folding the shared multiplier output
// into a per-bin leaky accumulator and reporting each updated value.
module dft_bin_scheduler
    import dft_pkg::*;
#(
    parameter int NUM_BINS    = 24,
    parameter int DECAY_SHIFT = 4,
    parameter int MAG_SHIFT   = 2
) (
    input  logic clk,
    input  logic rst,
    dft_bin_scheduler_if.master bus
);

    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

    state_t           state, state_nxt;
    logic [BIN_W-1:0] bin_q, bin_nxt;
    logic             drain_q, drain_nxt;
    logic             accept;

    logic [MAG_W-1:0] acc [NUM_BINS];
    logic             pipe_valid;
    logic [BIN_W-1:0] pipe_bin;
    logic [MAG_W-1:0] acc_rd;
    logic [MAG_W-1:0] acc_new;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bin_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            bin_q   <= bin_nxt;
            drain_q <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bin_nxt         = bin_q;
        drain_nxt       = 1'b0;
        accept          = 1'b0;
        bus.sampleReady = (state == IDLE);
        bus.enableIncr  = (state == ADVANCE);
        bus.frameDone   = (state == ADVANCE);
        bus.bin         = bin_q;
        unique case (state)
            IDLE: begin
                bin_nxt = '0;
                if (bus.sampleValid) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (bin_q == LAST_BIN) begin
                    bin_nxt   = '0;
                    state_nxt = DRAIN;
                end else begin
                    bin_nxt = bin_q + 1'b1;
                end
            end
            DRAIN: begin
                // drain_q marks the second of the two drain cycles
                if (drain_q) state_nxt = ADVANCE;
                else         drain_nxt = 1'b1;
            end
            ADVANCE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The table output for a bin arrives one cycle after the bin is issued.
    assign acc_rd = acc[pipe_bin];

    dft_bin_accum #(
        .DECAY_SHIFT (DECAY_SHIFT),
        .MAG_SHIFT   (MAG_SHIFT)
    ) u_accum (
        .acc       (acc_rd),
        .magnitude (bus.magnitude),
        .acc_new   (acc_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.multSample    <= '0;
            bus.sampleDropped <= 1'b0;
            bus.outValid      <= 1'b0;
            bus.outBin        <= '0;
            bus.outValue      <= '0;
            pipe_valid        <= 1'b0;
            pipe_bin          <= '0;
        end else begin
            if (accept) bus.multSample <= bus.inSample;
            bus.sampleDropped <= bus.sampleValid && (state != IDLE);
            pipe_valid        <= (state == ISSUE);
            pipe_bin          <= bin_q;
            bus.outValid      <= pipe_valid;
            if (pipe_valid) begin
                bus.outBin   <= pipe_bin;
                bus.outValue <= acc_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BINS; i++) acc[i] <= '0;
        end else if (pipe_valid) begin
            acc[pipe_bin] <= acc_new;
        end
    end

endmodule

// File: tb/tb_dft_bin_scheduler.sv
// Directed self-checking bench for dft_bin_scheduler with hand-computed accumulator values.
module tb_dft_bin_scheduler;

    localparam int N = 24;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    logic [31:0] mag_const;
    logic [31:0] mag_tbl;
    logic        use_table;
    logic [31:0] exp_val [32];

    dft_bin_scheduler_if bus ();

    dft_bin_scheduler #(
        .NUM_BINS    (N),
        .DECAY_SHIFT (4),
        .MAG_SHIFT   (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered stand-in for the sin/cos table: one cycle of latency from bin.
    always @(posedge clk) mag_tbl <= ({27'd0, bus.bin} + 32'd1) << 4;
    assign bus.magnitude = use_table ? mag_tbl : mag_const;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_exp(input logic [31:0] v);
        for (int k = 0; k < 32; k++) exp_val[k] = v;
    endtask

    // Accept one sample, then check every output cycle by cycle until IDLE returns.
    task automatic run_frame(input logic [15:0] s);
        int          ov_count;
        logic        e_ov;
        logic        e_done;
        logic [4:0]  e_bin;
        ov_count = 0;
        @(negedge clk);
        bus.inSample    = s;
        bus.sampleValid = 1'b1;
        checks++;
        if (bus.sampleReady !== 1'b1) begin
            errors++;
            $display("FAIL frame_ready got=%b want=1", bus.sampleReady);
        end
        for (int c = 1; c <= N + 4; c++) begin
            @(negedge clk);
            if (c == 1) bus.sampleValid = 1'b0;
            e_ov   = (c >= 3) && (c <= N + 2);
            e_done = (c == N + 3);
            e_bin  = (c >= 1 && c <= N) ? 5'(c - 1) : 5'd0;
            if (bus.outValid === 1'b1) ov_count++;
            checks++;
            if (bus.outValid !== e_ov) begin
                errors++;
                $display("FAIL out_valid c=%0d got=%b want=%b", c, bus.outValid, e_ov);
            end
            if (e_ov) begin
                checks++;
                if (bus.outBin !== 5'(c - 3)) begin
                    errors++;
                    $display("FAIL out_bin c=%0d got=%0d want=%0d", c, bus.outBin, c - 3);
                end
                checks++;
                if (bus.outValue !== exp_val[c - 3]) begin
                    errors++;
                    $display("FAIL out_value bin=%0d got=%h want=%h", c - 3, bus.outValue, exp_val[c - 3]);
                end
            end
            checks++;
            if (bus.frameDone !== e_done || bus.enableIncr !== e_done) begin
                errors++;
                $display("FAIL advance c=%0d got done=%b incr=%b want=%b", c, bus.frameDone, bus.enableIncr, e_done);
            end
            checks++;
            if (bus.bin !== e_bin) begin
                errors++;
                $display("FAIL bin c=%0d got=%0d want=%0d", c, bus.bin, e_bin);
            end
            checks++;
            if (bus.sampleReady !== (c == N + 4)) begin
                errors++;
                $display("FAIL ready c=%0d got=%b want=%b", c, bus.sampleReady, (c == N + 4));
            end
            checks++;
            if (bus.multSample !== s) begin
                errors++;
                $display("FAIL mult_sample c=%0d got=%h want=%h", c, bus.multSample, s);
            end
        end
        checks++;
        if (ov_count !== N) begin
            errors++;
            $display("FAIL out_valid_count got=%0d want=%0d", ov_count, N);
        end
    endtask

    task automatic test_reset();
        rst             = 1'b1;
        bus.sampleValid = 1'b0;
        bus.inSample    = '0;
        use_table       = 1'b0;
        mag_const       = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.sampleReady !== 1'b1 || bus.bin !== 5'd0 || bus.multSample !== 16'sd0) begin
            errors++;
            $display("FAIL reset_a got ready=%b bin=%0d mult=%h want 1/0/0", bus.sampleReady, bus.bin, bus.multSample);
        end
        checks++;
        if (bus.enableIncr !== 1'b0 || bus.outValid !== 1'b0 || bus.frameDone !== 1'b0 || bus.sampleDropped !== 1'b0) begin
            errors++;
            $display("FAIL reset_b got incr=%b ov=%b done=%b drop=%b want all 0",
                     bus.enableIncr, bus.outValid, bus.frameDone, bus.sampleDropped);
        end
        checks++;
        if (bus.outBin !== 5'd0 || bus.outValue !== 32'd0) begin
            errors++;
            $display("FAIL reset_c got out_bin=%0d out_value=%h want 0/0", bus.outBin, bus.outValue);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        mag_const = 32'h100;
        fill_exp(32'h40);
        run_frame(16'h0040);
        fill_exp(32'h7C);
        run_frame(16'h0040);
        fill_exp(32'hB5);
        run_frame(16'h0040);
    endtask

    task automatic test_bin_latency();
        do_reset();
        use_table = 1'b1;
        for (int k = 0; k < 32; k++) exp_val[k] = 32'(4 * (k + 1));
        run_frame(16'hBEEF);
        use_table = 1'b0;
    endtask

    task automatic test_saturation();
        logic [31:0] seq [6];
        seq[0] = 32'h3FFFFFFF;
        seq[1] = 32'h7BFFFFFF;
        seq[2] = 32'hB43FFFFF;
        seq[3] = 32'hE8FBFFFF;
        seq[4] = 32'hFFFFFFFF;
        seq[5] = 32'hFFFFFFFF;
        do_reset();
        mag_const = 32'hFFFFFFFF;
        for (int f = 0; f < 6; f++) begin
            fill_exp(seq[f]);
            run_frame(16'h7FFF);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e_mult;
        do_reset();
        mag_const = 32'h100;
        @(negedge clk);
        bus.inSample    = 16'd100;
        bus.sampleValid = 1'b1;
        checks++;
        if (bus.sampleReady !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_start got=%b want=1", bus.sampleReady);
        end
        for (int c = 1; c <= 57; c++) begin
            @(negedge clk);
            bus.inSample = 16'(c + 100);
            e_mult = 16'(100 + 28 * ((c - 1) / 28));
            checks++;
            if (bus.sampleReady !== (c % 28 == 0)) begin
                errors++;
                $display("FAIL b2b_ready c=%0d got=%b want=%b", c, bus.sampleReady, (c % 28 == 0));
            end
            checks++;
            if (bus.sampleDropped !== (c % 28 != 1)) begin
                errors++;
                $display("FAIL b2b_dropped c=%0d got=%b want=%b", c, bus.sampleDropped, (c % 28 != 1));
            end
            checks++;
            if (bus.multSample !== e_mult) begin
                errors++;
                $display("FAIL b2b_mult c=%0d got=%h want=%h", c, bus.multSample, e_mult);
            end
            if (bus.outValid === 1'b1) begin
                checks++;
                if (bus.outBin !== 5'((c % 28) - 3) || bus.outValue !== ((c < 28) ? 32'h40 : 32'h7C)) begin
                    errors++;
                    $display("FAIL b2b_out c=%0d got bin=%0d val=%h", c, bus.outBin, bus.outValue);
                end
            end
        end
        bus.sampleValid = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_abort();
        mag_const = 32'h100;
        @(negedge clk);
        bus.inSample    = 16'h1111;
        bus.sampleValid = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            if (c == 1) bus.sampleValid = 1'b0;
        end
        checks++;
        if (bus.bin !== 5'd10) begin
            errors++;
            $display("FAIL abort_bin got=%0d want=10", bus.bin);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.sampleReady !== 1'b1 || bus.bin !== 5'd0 || bus.outValid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got ready=%b bin=%0d ov=%b want 1/0/0", bus.sampleReady, bus.bin, bus.outValid);
        end
        for (int c = 13; c <= N + 8; c++) begin
            @(negedge clk);
            checks++;
            if (bus.outValid !== 1'b0 || bus.frameDone !== 1'b0 || bus.enableIncr !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet c=%0d got ov=%b done=%b incr=%b want 0",
                         c, bus.outValid, bus.frameDone, bus.enableIncr);
            end
        end
        mag_const = 32'h1234;
        fill_exp(32'h48D);
        run_frame(16'h7ABC);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single();
        test_bin_latency();
        test_saturation();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
